// File: rtl/cordic_pkg.sv
// Shared Q2.14 constants, state and quadrant types, and the quadrant sign/swap fix
// used by the full-circle CORDIC wrapper and its first-quadrant core.
package cordic_pkg;

  // Q2.14 constants: 1.0, pi/2 and the largest angle the core accepts
  localparam logic [15:0] ONE       = 16'h4000;
  localparam logic [15:0] K_HALFPI  = 16'h6487;
  localparam logic [15:0] ANGLE_MAX = 16'h6486;

  // Wrapper sequencing states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCALE = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } state_e;

  // Quadrant codes taken from the top two phase bits
  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  // Signed sine/cosine pair
  typedef struct packed {
    logic [15:0] sin;
    logic [15:0] cos;
  } sincos_t;

  // Two's complement negation; magnitudes never reach 0x8000
  function automatic logic [15:0] neg16(input logic [15:0] v);
    return 16'(~v + 16'd1);
  endfunction

  // Map first-quadrant magnitudes S/C onto the full circle
  function automatic sincos_t quad_fix(input quad_e q, input logic [15:0] s,
                                       input logic [15:0] c);
    sincos_t r;
    r.sin = s;
    r.cos = c;
    case (q)
      QUAD_0: begin
        r.sin = s;
        r.cos = c;
      end
      QUAD_1: begin
        r.sin = c;
        r.cos = neg16(s);
      end
      QUAD_2: begin
        r.sin = neg16(s);
        r.cos = neg16(c);
      end
      QUAD_3: begin
        r.sin = neg16(c);
        r.cos = s;
      end
      default: begin
        r.sin = s;
        r.cos = c;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cordic.sv
// First-quadrant iterative rotation-mode CORDIC. Angle in Q2.14 radians
// (0..ANGLE_MAX); returns unsigned sin/cos magnitudes in Q2.14 after a one-cycle
// o_done pulse. Internally carries two extra fraction bits to absorb shift rounding.
module cordic
  import cordic_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_angle,
  output logic [15:0] o_sin,
  output logic [15:0] o_cos,
  output logic        o_done
);

  // Gain-compensated start vector: 0.6072529 in Q4.16
  localparam logic signed [19:0] K_GAIN = 20'sd39797;

  // atan(2^-i) in Q4.16
  function automatic logic signed [19:0] atan_lut(input logic [3:0] i);
    logic signed [19:0] v;
    case (i)
      4'd0:    v = 20'sd51472;
      4'd1:    v = 20'sd30386;
      4'd2:    v = 20'sd16055;
      4'd3:    v = 20'sd8150;
      4'd4:    v = 20'sd4091;
      4'd5:    v = 20'sd2047;
      4'd6:    v = 20'sd1024;
      4'd7:    v = 20'sd512;
      4'd8:    v = 20'sd256;
      4'd9:    v = 20'sd128;
      4'd10:   v = 20'sd64;
      4'd11:   v = 20'sd32;
      4'd12:   v = 20'sd16;
      4'd13:   v = 20'sd8;
      4'd14:   v = 20'sd4;
      4'd15:   v = 20'sd2;
      default: v = 20'sd0;
    endcase
    return v;
  endfunction

  // Drop the guard bits with rounding and clamp to the 0..1.0 magnitude range
  function automatic logic [15:0] mag16(input logic signed [19:0] v);
    logic signed [19:0] rnd;
    logic [15:0]        m;
    rnd = (v + 20'sd2) >>> 2;
    if (rnd < 20'sd0) begin
      m = 16'h0000;
    end else if (rnd > $signed({4'h0, ONE})) begin
      m = ONE;
    end else begin
      m = rnd[15:0];
    end
    return m;
  endfunction

  logic signed [19:0] x_r, y_r, z_r;
  logic [3:0]         cnt_r;
  logic               busy_r, fin_r, done_r;
  logic [15:0]        sin_r, cos_r;

  logic signed [19:0] x_nx_s, y_nx_s, z_nx_s, atan_s, x_sh_s, y_sh_s, z_init_s;
  logic [15:0]        angle_c_s;

  // One micro-rotation toward z = 0, plus clamped load value
  always_comb begin
    atan_s = atan_lut(cnt_r);
    x_sh_s = x_r >>> cnt_r;
    y_sh_s = y_r >>> cnt_r;
    if (!z_r[19]) begin
      x_nx_s = x_r - y_sh_s;
      y_nx_s = y_r + x_sh_s;
      z_nx_s = z_r - atan_s;
    end else begin
      x_nx_s = x_r + y_sh_s;
      y_nx_s = y_r - x_sh_s;
      z_nx_s = z_r + atan_s;
    end
    if (i_angle > ANGLE_MAX) begin
      angle_c_s = ANGLE_MAX;
    end else begin
      angle_c_s = i_angle;
    end
    z_init_s = $signed({2'b00, angle_c_s, 2'b00});
  end

  // Load on start, iterate 16 times, then publish results with a done pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_r    <= 20'sd0;
      y_r    <= 20'sd0;
      z_r    <= 20'sd0;
      cnt_r  <= 4'd0;
      busy_r <= 1'b0;
      fin_r  <= 1'b0;
      done_r <= 1'b0;
      sin_r  <= 16'h0000;
      cos_r  <= 16'h0000;
    end else if (i_start) begin
      x_r    <= K_GAIN;
      y_r    <= 20'sd0;
      z_r    <= z_init_s;
      cnt_r  <= 4'd0;
      busy_r <= 1'b1;
      fin_r  <= 1'b0;
      done_r <= 1'b0;
    end else if (busy_r) begin
      x_r   <= x_nx_s;
      y_r   <= y_nx_s;
      z_r   <= z_nx_s;
      cnt_r <= cnt_r + 4'd1;
      if (cnt_r == 4'd15) begin
        busy_r <= 1'b0;
        fin_r  <= 1'b1;
      end
      done_r <= 1'b0;
    end else if (fin_r) begin
      sin_r  <= mag16(y_r);
      cos_r  <= mag16(x_r);
      fin_r  <= 1'b0;
      done_r <= 1'b1;
    end else begin
      done_r <= 1'b0;
    end
  end

  assign o_sin  = sin_r;
  assign o_cos  = cos_r;
  assign o_done = done_r;

endmodule

// File: rtl/cordic_quadrant.sv
// Full-circle wrapper: takes a phase in turns, reduces it to a first-quadrant
// angle, runs the cordic core, and restores signs/swaps to give signed sin/cos.
module cordic_quadrant #(
  parameter logic [15:0] K_HALFPI = cordic_pkg::K_HALFPI,
  parameter int          W        = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_phase,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_sin,
  output logic [W-1:0] o_cos,
  output logic         o_valid,
  input  logic         i_ready
);
  import cordic_pkg::*;

  state_e      state_r;
  quad_e       q_r;
  logic [13:0] r_r;
  logic [15:0] angle_r;
  logic        start_r;
  logic        wait_first_r;
  logic        ready_r;
  logic        valid_r;
  logic [15:0] sin_r, cos_r;

  logic [15:0] scaled_s;
  logic [15:0] core_sin_s, core_cos_s;
  logic        core_done_s;
  logic        core_rst_s;
  sincos_t     fix_s;

  // Residual phase to radians (truncated) and quadrant restoration of core output
  always_comb begin
    scaled_s = 16'((32'(r_r) * 32'(K_HALFPI)) >> 14);
    fix_s    = quad_fix(q_r, core_sin_s, core_cos_s);
  end

  assign core_rst_s = !i_rst_n;

  cordic u_cordic (
    .i_clk   (i_clk),
    .i_rst   (core_rst_s),
    .i_start (start_r),
    .i_angle (angle_r),
    .o_sin   (core_sin_s),
    .o_cos   (core_cos_s),
    .o_done  (core_done_s)
  );

  // Sequencer: accept phase, scale, start core, wait for done, hold result
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= IDLE;
      q_r          <= QUAD_0;
      r_r          <= 14'd0;
      angle_r      <= 16'h0000;
      start_r      <= 1'b0;
      wait_first_r <= 1'b0;
      ready_r      <= 1'b0;
      valid_r      <= 1'b0;
      sin_r        <= 16'h0000;
      cos_r        <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          valid_r <= 1'b0;
          if (i_valid && ready_r) begin
            q_r     <= quad_e'(i_phase[15:14]);
            r_r     <= i_phase[13:0];
            ready_r <= 1'b0;
            state_r <= SCALE;
          end else begin
            ready_r <= 1'b1;
          end
        end
        SCALE: begin
          angle_r <= scaled_s;
          start_r <= 1'b1;
          state_r <= START;
        end
        START: begin
          start_r      <= 1'b0;
          wait_first_r <= 1'b1;
          state_r      <= WAIT;
        end
        WAIT: begin
          // The first WAIT cycle ignores done so a stale pulse cannot complete us
          wait_first_r <= 1'b0;
          if (!wait_first_r && core_done_s) begin
            sin_r   <= fix_s.sin;
            cos_r   <= fix_s.cos;
            valid_r <= 1'b1;
            state_r <= HOLD;
          end
        end
        HOLD: begin
          if (i_ready) begin
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: begin
          start_r <= 1'b0;
          ready_r <= 1'b0;
          valid_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign o_ready = ready_r;
  assign o_valid = valid_r;
  assign o_sin   = sin_r;
  assign o_cos   = cos_r;

endmodule

// File: tb/tb_cordic_quadrant.sv
// Directed bench for cordic_quadrant: reset values, the four axes, 45-degree
// points, phase wrap, backpressure, a sparse sweep and reset during WAIT.
module tb_cordic_quadrant;
  import cordic_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_phase;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] o_sin, o_cos;
  logic        o_valid;
  logic        i_ready;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;

  always #5 clk = ~clk;

  cordic_quadrant #(.K_HALFPI(16'h6487), .W(16)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_phase (i_phase),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_sin   (o_sin),
    .o_cos   (o_cos),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  // Count completed output handshakes
  always @(posedge clk) begin
    if (rst_n && o_valid && i_ready) hs_count++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic [15:0] obs, input int exp, input int tol);
    int d;
    d = int'($signed(obs)) - exp;
    if (d < 0) d = -d;
    checks++;
    assert (d <= tol) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, $signed(obs), exp, tol);
    end
  endtask

  task automatic send(input logic [15:0] ph);
    int n;
    n = 0;
    while (o_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("send_ready", {31'd0, o_ready}, 32'd1);
    i_phase = ph;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_valid(output logic [15:0] s, output logic [15:0] c);
    int n;
    n = 0;
    while (o_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("valid_timeout", {31'd0, o_valid}, 32'd1);
    s = o_sin;
    c = o_cos;
  endtask

  logic [15:0] ph_tab [7] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h2000, 16'h6000, 16'hFFFF};
  int          es_tab [7] = '{0, 16384, 0, -16384, 11585, 11585, -2};
  int          ec_tab [7] = '{16384, 0, -16384, 0, 11585, -11585, 16384};
  logic [15:0] ea_tab [7] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3243, 16'h3243, 16'h6485};

  initial begin
    logic [15:0] s, c, s0, c0;
    logic        stable, ready_low, extra_valid;
    int          hs_before;
    logic [15:0] ph;
    real         ang;
    int          es, ec;

    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_phase = 16'h0000;
    i_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_ready", {31'd0, o_ready}, 32'd0);
    check_eq("rst_valid", {31'd0, o_valid}, 32'd0);
    check_eq("rst_sin", {16'd0, o_sin}, 32'd0);
    check_eq("rst_cos", {16'd0, o_cos}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("ready_after_rst", {31'd0, o_ready}, 32'd1);

    // Directed axis, 45-degree and wrap points
    for (int i = 0; i < 7; i++) begin
      send(ph_tab[i]);
      wait_valid(s, c);
      check_eq($sformatf("angle_%h", ph_tab[i]), {16'd0, u_dut.angle_r}, {16'd0, ea_tab[i]});
      check_near($sformatf("sin_%h", ph_tab[i]), s, es_tab[i], 4);
      check_near($sformatf("cos_%h", ph_tab[i]), c, ec_tab[i], 4);
      @(negedge clk);
      if (i == 0) begin
        check_eq("valid_one_cycle", {31'd0, o_valid}, 32'd0);
        check_eq("ready_returns", {31'd0, o_ready}, 32'd1);
      end
    end

    // Backpressure: hold i_ready low, ignored i_valid pulse, one transfer on release
    i_ready = 1'b0;
    send(16'h2000);
    wait_valid(s0, c0);
    hs_before = hs_count;
    stable = 1'b1;
    ready_low = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        i_phase = 16'h8000;
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      @(negedge clk);
      if (o_valid !== 1'b1 || o_sin !== s0 || o_cos !== c0) stable = 1'b0;
      if (o_ready !== 1'b0) ready_low = 1'b0;
    end
    i_valid = 1'b0;
    check_eq("bp_stable", {31'd0, stable}, 32'd1);
    check_eq("bp_ready_low", {31'd0, ready_low}, 32'd1);
    check_near("bp_sin", s0, 11585, 4);
    i_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_valid", {31'd0, o_valid}, 32'd0);
    extra_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (o_valid === 1'b1) extra_valid = 1'b1;
    end
    check_eq("bp_no_extra", {31'd0, extra_valid}, 32'd0);
    check_eq("bp_one_transfer", 32'(hs_count - hs_before), 32'd1);

    // Sparse sweep against a real-valued model with per-quadrant sign checks
    for (int k = 0; k < 32; k++) begin
      ph = 16'(k * 2048 + 291);
      send(ph);
      wait_valid(s, c);
      ang = 6.283185307179586 * real'(ph) / 65536.0;
      es = $rtoi(16384.0 * $sin(ang) + (($sin(ang) >= 0.0) ? 0.5 : -0.5));
      ec = $rtoi(16384.0 * $cos(ang) + (($cos(ang) >= 0.0) ? 0.5 : -0.5));
      check_near($sformatf("sweep_sin_%h", ph), s, es, 6);
      check_near($sformatf("sweep_cos_%h", ph), c, ec, 6);
      check_eq($sformatf("sweep_sign_%h", ph), {30'd0, s[15], c[15]},
               {30'd0, (ph[15:14] >= 2'd2), (ph[15:14] == 2'd1 || ph[15:14] == 2'd2)});
      @(negedge clk);
    end

    // Reset asserted while waiting on the core
    send(16'h2000);
    repeat (4) @(negedge clk);
    check_eq("in_wait", {29'd0, u_dut.state_r}, {29'd0, WAIT});
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", {31'd0, o_valid}, 32'd0);
    check_eq("midrst_sin", {16'd0, o_sin}, 32'd0);
    check_eq("midrst_cos", {16'd0, o_cos}, 32'd0);
    check_eq("midrst_ready", {31'd0, o_ready}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    extra_valid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (o_valid === 1'b1) extra_valid = 1'b1;
    end
    check_eq("post_rst_no_stale", {31'd0, extra_valid}, 32'd0);
    send(16'h4000);
    wait_valid(s, c);
    check_near("post_rst_sin", s, 16384, 4);
    check_near("post_rst_cos", c, 0, 4);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
